// File: rtl/regfile_writeback_queue.sv
// Write-back queue that buffers datapath results and drains them into the register file write port.
// Optional pending-data forwarding for the two read addresses is enabled by defining WB_FORWARD_EN.
module regfile_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_reg,
    input  logic [7:0]    in_data,
    input  logic          drain_en,
    output logic          regWrite,
    output logic [4:0]    write_register,
    output logic [7:0]    write_data,
    input  logic [4:0]    lookup_reg_1,
    input  logic [4:0]    lookup_reg_2,
    output logic          fwd_hit_1,
    output logic          fwd_hit_2,
    output logic [7:0]    fwd_data_1,
    output logic [7:0]    fwd_data_2,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [4:0]    reg_mem  [DEPTH];
    logic [7:0]    data_mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;

    // Handshake: a request transfers on any edge where in_valid & in_ready;
    // register 0 requests transfer but are dropped because r0 is never written.
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = ~full;
    assign push     = in_valid & in_ready & (in_reg != 5'd0);
    assign regWrite = drain_en & ~empty;
    assign pop      = regWrite;

    assign write_register = empty ? 5'd0 : reg_mem[head];
    assign write_data     = empty ? 8'd0 : data_mem[head];

    always_ff @(posedge clk) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            reg_mem[tail]  <= in_reg;
            data_mem[tail] <= in_data;
        end
    end

`ifdef WB_FORWARD_EN
    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit_1  = 1'b0;
        fwd_hit_2  = 1'b0;
        fwd_data_1 = 8'd0;
        fwd_data_2 = 8'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                if (lookup_reg_1 != 5'd0 && reg_mem[head + PW'(i)] == lookup_reg_1) begin
                    fwd_hit_1  = 1'b1;
                    fwd_data_1 = data_mem[head + PW'(i)];
                end
                if (lookup_reg_2 != 5'd0 && reg_mem[head + PW'(i)] == lookup_reg_2) begin
                    fwd_hit_2  = 1'b1;
                    fwd_data_2 = data_mem[head + PW'(i)];
                end
            end
        end
    end
`else
    logic unused_lookup;
    assign unused_lookup = ^{lookup_reg_1, lookup_reg_2};
    assign fwd_hit_1  = 1'b0;
    assign fwd_hit_2  = 1'b0;
    assign fwd_data_1 = 8'd0;
    assign fwd_data_2 = 8'd0;
`endif
endmodule
